// File: rtl/chunked_wide_adder_pkg.sv
// rtl/chunked_wide_adder_pkg.sv - shared state encoding and width helpers for the chunked wide adder
package chunked_wide_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int total_width(input int n, input int words);
        return n * words;
    endfunction

    // Chunk index never needs fewer than one bit.
    function automatic int idx_width(input int words);
        return (words <= 2) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/chunked_wide_adder_if.sv
// rtl/chunked_wide_adder_if.sv - request/result bundle between a requester and the chunked wide adder
interface chunked_wide_adder_if #(
    parameter int N     = 8,
    parameter int WORDS = 4
);
    localparam int W = N * WORDS;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;

    modport master (
        output start, a, b, c_in,
        input  busy, done, sum, c_out, ovf
    );

    modport slave (
        input  start, a, b, c_in,
        output busy, done, sum, c_out, ovf
    );
endinterface

// File: rtl/chunked_wide_adder_ripple.sv
// rtl/chunked_wide_adder_ripple.sv - N-bit ripple-carry adder built from chained full adders
module N_bit_Ripple_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[N];
endmodule

// File: rtl/chunked_wide_adder.sv
// rtl/chunked_wide_adder.sv - W-bit adder that reuses one N-bit ripple adder over WORDS cycles, LS chunk first
module chunked_wide_adder
    import chunked_wide_adder_pkg::*;
#(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    chunked_wide_adder_if.slave  bus
);
    localparam int W  = total_width(N, WORDS);
    localparam int IW = idx_width(WORDS);

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    work_q, work_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            c_out_q, c_out_d;
    logic            ovf_q, ovf_d;

    logic [N-1:0]    chunk_sum;
    logic            chunk_cout;

    N_bit_Ripple_adder #(.N(N)) u_ripple (
        .a    (a_q[idx_q*N +: N]),
        .b    (b_q[idx_q*N +: N]),
        .cin  (carry_q),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        case (state_q)
            // DONE accepts a new request directly so back-to-back adds skip IDLE.
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.c_in;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                work_d[idx_q*N +: N] = chunk_sum;
                carry_d              = chunk_cout;
                if (idx_q == IW'(WORDS - 1)) begin
                    idx_d   = '0;
                    sum_d   = work_d;
                    c_out_d = chunk_cout;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (work_d[W-1] != a_q[W-1]);
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy  = (state_q == ST_RUN);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;
    assign bus.ovf   = ovf_q;
endmodule
